// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;
    localparam int INSTR_W    = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = 128;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    function automatic logic [INSTR_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic [1:0]        k);
        return line[k*INSTR_W +: INSTR_W];
    endfunction
endpackage

// File: rtl/ifq_storage.sv
// Entry array for the fetch queue: 4-wide masked write at tail, async read at head.
module ifq_storage
    import ifq_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic [LINE_WORDS-1:0]           wr_en,
    input  logic [LINE_WORDS-1:0][AW-1:0]   wr_idx,
    input  ifq_entry_t [LINE_WORDS-1:0]     wr_data,
    input  logic [AW-1:0]                   rd_idx,
    output ifq_entry_t                      rd_data
);
    ifq_entry_t mem_q [DEPTH];
    ifq_entry_t mem_d [DEPTH];

    // Lanes within one push always target distinct slots, so order is irrelevant.
    always_comb begin
        mem_d = mem_q;
        for (int l = 0; l < LINE_WORDS; l++) begin
            if (wr_en[l]) mem_d[wr_idx[l]] = wr_data[l];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC, line splitter and circular instruction queue feeding dispatch.
// Optional IFQ_PERF_CNT_EN adds stall_cnt / redirect_cnt performance counters.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    output logic [31:0]                rom_addr,
    input  logic [LINE_W-1:0]          rom_data,
    input  logic                       br_redirect,
    input  logic [31:0]                br_target,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH):0]     q_count
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                redirect_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    off;
    logic [2:0]    n_words;
    logic [CW-1:0] space;
    logic          room, push, pop;
    logic          unused_tgt;

    assign off        = pc_q[3:2];
    assign n_words    = 3'd4 - {1'b0, off};
    assign space      = CW'(DEPTH) - count_q;
    assign room       = space >= CW'(n_words);
    assign push       = fetch_en & ~br_redirect & room;
    assign pop        = (count_q != '0) & instr_ready & ~br_redirect;
    assign unused_tgt = ^br_target[1:0];

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (br_redirect) begin
            pc_d    = {br_target[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(n_words);
                pc_d   = {pc_q[31:4] + 28'd1, 4'b0000};
            end
            if (pop) head_d = head_q + AW'(1);
            count_d = count_q + (push ? CW'(n_words) : '0) - (pop ? CW'(1) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Lane l carries word off+l of the line into slot tail+l.
    logic [LINE_WORDS-1:0]         wr_en;
    logic [LINE_WORDS-1:0][AW-1:0] wr_idx;
    ifq_entry_t [LINE_WORDS-1:0]   wr_data;
    ifq_entry_t                    rd_data;

    for (genvar l = 0; l < LINE_WORDS; l++) begin : g_lane
        logic [1:0] wsel;
        assign wsel             = off + 2'(l);
        assign wr_en[l]         = push & (3'(l) < n_words);
        assign wr_idx[l]        = tail_q + AW'(l);
        assign wr_data[l].instr = line_word(rom_data, wsel);
        assign wr_data[l].pc    = {pc_q[31:4], wsel, 2'b00};
    end

    ifq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (head_q),
        .rd_data (rd_data)
    );

    assign rom_addr    = pc_q;
    assign q_count     = count_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? rd_data.instr : '0;
    assign instr_pc    = instr_valid ? rd_data.pc    : '0;

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q + {31'd0, fetch_en & ~br_redirect & ~room};
        redirect_cnt_d = redirect_cnt_q + {31'd0, br_redirect};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=16, RESET_PC=0).
module tb_instr_fetch_queue;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_en;
    logic [31:0]  rom_addr;
    logic [127:0] rom_data;
    logic         br_redirect;
    logic [31:0]  br_target;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic [4:0]   q_count;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  redirect_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM: word at byte address A holds 0x100 + A/4.
    always_comb begin
        rom_data = '0;
        for (int k = 0; k < 4; k++)
            rom_data[k*32 +: 32] = 32'h100 + {2'b00, rom_addr[31:4], 2'(k)};
    end

    instr_fetch_queue #(.DEPTH(16), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en     (fetch_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .q_count      (q_count)
`ifdef IFQ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b0;
        br_redirect = 1'b0; br_target = '0;
        tick(); tick();
        total++; if (rom_addr !== 32'h0) begin bad++; $display("FAIL rst_rom_addr got=%h exp=%h", rom_addr, 32'h0); end
        total++; if (q_count !== 5'd0) begin bad++; $display("FAIL rst_q_count got=%0d exp=0", q_count); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h/%h exp=0/0", instr, instr_pc); end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (rom_addr !== 32'((i > 4 ? 4 : i) * 16) || q_count !== 5'((i > 4 ? 4 : i) * 4)) begin
                bad++;
                $display("FAIL fill_step%0d got addr=%h cnt=%0d exp addr=%h cnt=%0d", i, rom_addr, q_count,
                         (i > 4 ? 4 : i) * 16, (i > 4 ? 4 : i) * 4);
            end
        end
        total++; if (instr !== 32'h100 || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin bad++; $display("FAIL fill_head got=%h/%h v=%b exp=100/0 v=1", instr, instr_pc, instr_valid); end
    endtask

    task automatic test_drain();
        int exp_cnt  [7] = '{16, 15, 14, 13, 12, 15, 14};
        int exp_addr [7] = '{'h40, 'h40, 'h40, 'h40, 'h40, 'h50, 'h50};
        instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (instr !== 32'(32'h100 + k) || instr_pc !== 32'(4 * k)) begin
                bad++; $display("FAIL drain_instr%0d got=%h/%h exp=%h/%h", k, instr, instr_pc, 32'h100 + k, 4 * k);
            end
            total++;
            if (q_count !== 5'(exp_cnt[k]) || rom_addr !== 32'(exp_addr[k])) begin
                bad++; $display("FAIL drain_cnt%0d got cnt=%0d addr=%h exp cnt=%0d addr=%h", k, q_count, rom_addr, exp_cnt[k], exp_addr[k]);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b0;
        repeat (4) tick();
        instr_ready = 1'b0;
        total++; if (q_count !== 5'd9) begin bad++; $display("FAIL redir_pre_cnt got=%0d exp=9", q_count); end
        br_redirect = 1'b1; br_target = 32'h28; fetch_en = 1'b1;
        tick();
        br_redirect = 1'b0;
        total++; if (q_count !== 5'd0 || instr_valid !== 1'b0 || instr !== 32'h0) begin bad++; $display("FAIL redir_flush got cnt=%0d v=%b i=%h exp cnt=0 v=0 i=0", q_count, instr_valid, instr); end
        total++; if (rom_addr !== 32'h28) begin bad++; $display("FAIL redir_addr got=%h exp=28", rom_addr); end
        tick();
        fetch_en = 1'b0; instr_ready = 1'b1;
        total++; if (q_count !== 5'd2 || rom_addr !== 32'h30) begin bad++; $display("FAIL redir_push got cnt=%0d addr=%h exp cnt=2 addr=30", q_count, rom_addr); end
        total++; if (instr !== 32'h10A || instr_pc !== 32'h28) begin bad++; $display("FAIL redir_head0 got=%h/%h exp=10a/28", instr, instr_pc); end
        tick();
        total++; if (instr !== 32'h10B || instr_pc !== 32'h2C || q_count !== 5'd1) begin bad++; $display("FAIL redir_head1 got=%h/%h cnt=%0d exp=10b/2c cnt=1", instr, instr_pc, q_count); end
    endtask

    task automatic test_redirect_ready();
        instr_ready = 1'b0; fetch_en = 1'b1;
        tick();
        total++; if (q_count !== 5'd5) begin bad++; $display("FAIL rr_pre_cnt got=%0d exp=5", q_count); end
        br_redirect = 1'b1; br_target = 32'h13; instr_ready = 1'b1;
        total++; if (instr !== 32'h10B || instr_valid !== 1'b1) begin bad++; $display("FAIL rr_head got=%h v=%b exp=10b v=1", instr, instr_valid); end
        tick();
        br_redirect = 1'b0; instr_ready = 1'b0;
        total++; if (q_count !== 5'd0 || instr_valid !== 1'b0 || rom_addr !== 32'h10) begin bad++; $display("FAIL rr_flush got cnt=%0d v=%b addr=%h exp cnt=0 v=0 addr=10", q_count, instr_valid, rom_addr); end
        tick();
        total++; if (q_count !== 5'd4 || instr !== 32'h104 || instr_pc !== 32'h10 || rom_addr !== 32'h20) begin bad++; $display("FAIL rr_push got cnt=%0d i=%h pc=%h addr=%h exp cnt=4 i=104 pc=10 addr=20", q_count, instr, instr_pc, rom_addr); end
    endtask

    task automatic test_back_to_back();
        br_redirect = 1'b1; br_target = 32'h80;
        tick();
        br_target = 32'h34;
        tick();
        br_redirect = 1'b0;
        total++; if (rom_addr !== 32'h34 || q_count !== 5'd0) begin bad++; $display("FAIL b2b_addr got addr=%h cnt=%0d exp addr=34 cnt=0", rom_addr, q_count); end
        tick();
        fetch_en = 1'b0;
        total++; if (q_count !== 5'd3 || instr !== 32'h10D || instr_pc !== 32'h34 || rom_addr !== 32'h40) begin bad++; $display("FAIL b2b_push got cnt=%0d i=%h pc=%h addr=%h exp cnt=3 i=10d pc=34 addr=40", q_count, instr, instr_pc, rom_addr); end
    endtask

    task automatic test_midop_reset_perf();
        rst_n = 1'b0;
        #1;
        total++; if (q_count !== 5'd0 || instr_valid !== 1'b0 || rom_addr !== 32'h0 || instr !== 32'h0) begin bad++; $display("FAIL midrst got cnt=%0d v=%b addr=%h i=%h exp all 0", q_count, instr_valid, rom_addr, instr); end
        tick();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b0;
`ifdef IFQ_PERF_CNT_EN
        total++; if (stall_cnt !== 32'd0 || redirect_cnt !== 32'd0) begin bad++; $display("FAIL perf_rst got=%0d/%0d exp=0/0", stall_cnt, redirect_cnt); end
`endif
        repeat (4) tick();
        total++; if (q_count !== 5'd16 || rom_addr !== 32'h40) begin bad++; $display("FAIL refill got cnt=%0d addr=%h exp cnt=16 addr=40", q_count, rom_addr); end
        repeat (5) tick();
        fetch_en = 1'b0;
        total++; if (q_count !== 5'd16 || rom_addr !== 32'h40) begin bad++; $display("FAIL full_hold got cnt=%0d addr=%h exp cnt=16 addr=40", q_count, rom_addr); end
`ifdef IFQ_PERF_CNT_EN
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt); end
`endif
        br_redirect = 1'b1; br_target = 32'h0;
        tick(); tick();
        br_redirect = 1'b0;
        total++; if (q_count !== 5'd0) begin bad++; $display("FAIL perf_flush got=%0d exp=0", q_count); end
`ifdef IFQ_PERF_CNT_EN
        total++; if (redirect_cnt !== 32'd2 || stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_redir got=%0d/%0d exp=2/5", redirect_cnt, stall_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_drain();
        test_redirect();
        test_redirect_ready();
        test_back_to_back();
        test_midop_reset_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
